// File: rtl/alu_pkg.sv
// Shared ALU constants: default operand/select widths and the select-code encoding
// used by the alu, the issue stage and any bench driving them.
package alu_pkg;

   localparam int ALU_WIDTH = 32;
   localparam int ALU_OPW   = 3;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_SHL  = 3'd5,
      OP_SHR  = 3'd6,
      OP_SLTU = 3'd7
   } alu_op_e;

endpackage

// File: rtl/alu.sv
// 32-bit ALU with one output register stage (out follows a/b/s by one clock).
// Shifts use the low five bits of b; SLTU returns 1 when a < b unsigned.
module alu
   import alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ALU_WIDTH-1:0] a,
   input  logic [ALU_WIDTH-1:0] b,
   input  logic [ALU_OPW-1:0]   s,
   output logic [ALU_WIDTH-1:0] out
);

   logic [ALU_WIDTH-1:0] result;

   always_comb begin
      result = '0;
      unique case (alu_op_e'(s))
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHL:  result = a << b[4:0];
         OP_SHR:  result = a >> b[4:0];
         OP_SLTU: result = (a < b) ? ALU_WIDTH'(1) : '0;
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) out <= '0;
      else      out <= result;
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; push when full and pop when empty are ignored.
// Head entry is presented combinationally on dout.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rptr[AW-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count = wptr - rptr;

endmodule

// File: rtl/alu_issue_stage.sv
// Buffers ALU commands, issues them under a result-FIFO credit limit and collects
// results after ALU_LAT+1 clocks, so backpressure on the result port never drops data.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int OPW     = ALU_OPW,
   parameter int DEPTH   = 4,
   parameter int RDEPTH  = 4,
   parameter int ALU_LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [WIDTH-1:0]           cmd_a,
   input  logic [WIDTH-1:0]           cmd_b,
   input  logic [OPW-1:0]             cmd_s,
   output logic [WIDTH-1:0]           alu_a,
   output logic [WIDTH-1:0]           alu_b,
   output logic [OPW-1:0]             alu_s,
   input  logic [WIDTH-1:0]           alu_out,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [WIDTH-1:0]           res_data,
   output logic [OPW-1:0]             res_op,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = 2*WIDTH + OPW;
   localparam int RW = WIDTH + OPW;

   logic                        ready_q;
   logic                        cmd_full;
   logic                        cmd_empty;
   logic [CW-1:0]               cmd_head;
   logic                        res_full;
   logic                        res_empty;
   logic [RW-1:0]               res_head;
   logic [$clog2(RDEPTH+1)-1:0] res_cnt;
   logic                        issue;
   int                          inflight;
   logic [ALU_LAT:0]            pipe_v;
   logic [OPW-1:0]              pipe_s [ALU_LAT+1];

   // ready_q keeps cmd_ready low throughout reset and for the release edge itself.
   assign cmd_ready = ready_q && !cmd_full;

   sync_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid && cmd_ready),
      .pop   (issue),
      .din   ({cmd_a, cmd_b, cmd_s}),
      .dout  (cmd_head),
      .full  (cmd_full),
      .empty (cmd_empty),
      .count (count)
   );

   // NOTE: every always_comb target gets a default first so no latch is inferred.
   always_comb begin
      inflight = 0;
      for (int i = 0; i <= ALU_LAT; i++) inflight += int'(pipe_v[i]);
   end

   // Each issued command reserves a result slot until it is popped from the result FIFO.
   assign issue = !cmd_empty && !res_full && ((inflight + int'(res_cnt)) < RDEPTH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q <= 1'b0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_s   <= '0;
         pipe_v  <= '0;
      end else begin
         ready_q <= 1'b1;
         if (issue) begin
            alu_a <= cmd_head[CW-1 -: WIDTH];
            alu_b <= cmd_head[CW-WIDTH-1 -: WIDTH];
            alu_s <= cmd_head[OPW-1:0];
         end
         pipe_v[0] <= issue;
         for (int i = 1; i <= ALU_LAT; i++) pipe_v[i] <= pipe_v[i-1];
      end
   end

   // Select codes travel alongside the valid bits; only meaningful where pipe_v is set.
   always_ff @(posedge clk) begin
      pipe_s[0] <= cmd_head[OPW-1:0];
      for (int i = 1; i <= ALU_LAT; i++) pipe_s[i] <= pipe_s[i-1];
   end

   sync_fifo #(.WIDTH(RW), .DEPTH(RDEPTH)) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pipe_v[ALU_LAT]),
      .pop   (res_valid && res_ready),
      .din   ({alu_out, pipe_s[ALU_LAT]}),
      .dout  (res_head),
      .full  (res_full),
      .empty (res_empty),
      .count (res_cnt)
   );

   assign res_valid = !res_empty;
   assign res_data  = res_head[RW-1 -: WIDTH];
   assign res_op    = res_head[OPW-1:0];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and random checks of alu_issue_stage driving a real alu; expected results
// come from hand-computed constants and an independent ALU reference function.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [2:0]  cmd_s;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_s;
   logic [31:0] alu_out;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [2:0]  res_op;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.WIDTH(32), .OPW(3), .DEPTH(4), .RDEPTH(4), .ALU_LAT(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_s     (cmd_s),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_s     (alu_s),
      .alu_out   (alu_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_op    (res_op),
      .count     (count)
   );

   alu u_alu (
      .clk (clk),
      .rst (rst),
      .a   (alu_a),
      .b   (alu_b),
      .s   (alu_s),
      .out (alu_out)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] s);
      case (s)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << b[4:0];
         3'd6:    return a >> b[4:0];
         default: return (a < b) ? 32'd1 : 32'd0;
      endcase
   endfunction

   // One step: wait for the rising edge, then settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bp(input int i);
      cmd_a = 32'h100 + 32'(i) * 32'd7;
      cmd_b = 32'(i) + 32'd1;
      cmd_s = 3'(i);
   endtask

   logic [31:0] sweep_exp [8];
   logic [34:0] sb [$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int idx, first, last, acc, stale, sent, cyc;
      logic taken, popped;
      logic [31:0] ea;

      sweep_exp = '{32'h69, 32'h55, 32'h0A, 32'h5F, 32'h55, 32'h17C00, 32'h0, 32'h0};

      // Reset held with a command offered: nothing may be accepted.
      rst = 1'b0; cmd_valid = 1'b1; cmd_a = 32'h5F; cmd_b = 32'h0A; cmd_s = 3'd0;
      res_ready = 1'b0;
      repeat (3) tick();
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_alu_a",     64'(alu_a),     64'd0);
      check("rst_alu_b",     64'(alu_b),     64'd0);
      check("rst_alu_s",     64'(alu_s),     64'd0);
      check("rst_count",     64'(count),     64'd0);
      cmd_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("post_rst_ready", 64'(cmd_ready), 64'd1);
      check("post_rst_count", 64'(count),     64'd0);

      // Single op: accept at edge 0, result visible after edge 3.
      cmd_valid = 1'b1; cmd_a = 32'h5F; cmd_b = 32'h0A; cmd_s = 3'd0; res_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("single_e0_valid", 64'(res_valid), 64'd0);
      tick();
      check("single_e1_alu_a", 64'(alu_a), 64'h5F);
      check("single_e1_valid", 64'(res_valid), 64'd0);
      tick();
      check("single_e2_valid", 64'(res_valid), 64'd0);
      tick();
      check("single_e3_valid", 64'(res_valid), 64'd1);
      check("single_data", 64'(res_data), 64'h69);
      check("single_op",   64'(res_op),   64'd0);
      tick();
      check("single_popped", 64'(res_valid), 64'd0);

      // Sweep all selects back-to-back.
      idx = 0; first = -1; last = -1;
      for (int c = 0; c < 30; c++) begin
         cmd_valid = (c < 8);
         cmd_a = 32'h5F; cmd_b = 32'h0A; cmd_s = 3'(c);
         if (res_valid) begin
            if (idx < 8) begin
               check($sformatf("sweep_data%0d", idx), 64'(res_data), 64'(sweep_exp[idx]));
               check($sformatf("sweep_op%0d", idx),   64'(res_op),   64'(idx));
            end
            if (first < 0) first = c;
            last = c;
            idx++;
         end
         tick();
      end
      cmd_valid = 1'b0;
      check("sweep_count",  64'(idx), 64'd8);
      check("sweep_spread", 64'(last - first), 64'd7);

      // Backpressure: 9 offered with res_ready low, then drain.
      res_ready = 1'b0; acc = 0;
      for (int c = 0; c < 12; c++) begin
         cmd_valid = (acc < 9);
         drive_bp(acc);
         taken = cmd_valid && cmd_ready;
         tick();
         if (taken) acc++;
      end
      check("bp_accepted",  64'(acc),       64'd8);
      check("bp_count",     64'(count),     64'd4);
      check("bp_ready_low", 64'(cmd_ready), 64'd0);
      check("bp_res_valid", 64'(res_valid), 64'd1);
      res_ready = 1'b1; idx = 0;
      for (int c = 0; c < 40 && idx < 9; c++) begin
         cmd_valid = (acc < 9);
         drive_bp(acc);
         taken = cmd_valid && cmd_ready;
         if (res_valid) begin
            ea = model(32'h100 + 32'(idx) * 32'd7, 32'(idx) + 32'd1, 3'(idx));
            check($sformatf("bp_res%0d", idx), {29'd0, res_op, res_data}, {29'd0, 3'(idx), ea});
            idx++;
         end
         tick();
         if (taken) acc++;
      end
      cmd_valid = 1'b0;
      check("bp_drained",  64'(idx),   64'd9);
      check("bp_all_acc",  64'(acc),   64'd9);
      check("bp_count_0",  64'(count), 64'd0);

      // Reset mid-stream with work buffered and in flight.
      res_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         cmd_valid = 1'b1; cmd_a = 32'h40 + 32'(c); cmd_b = 32'd2; cmd_s = 3'd0;
         tick();
      end
      cmd_valid = 1'b0;
      #3 rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      check("mid_count",     64'(count),     64'd0);
      check("mid_res_valid", 64'(res_valid), 64'd0);
      check("mid_alu_a",     64'(alu_a),     64'd0);
      res_ready = 1'b1; stale = 0;
      for (int c = 0; c < 10; c++) begin
         if (res_valid) stale++;
         tick();
      end
      check("mid_no_stale", 64'(stale), 64'd0);
      cmd_valid = 1'b1; cmd_a = 32'd7; cmd_b = 32'd3; cmd_s = 3'd1;
      tick();
      cmd_valid = 1'b0;
      idx = 0;
      for (int c = 0; c < 10 && idx == 0; c++) begin
         if (res_valid) begin
            check("mid_fresh", {29'd0, res_op, res_data}, {29'd0, 3'd1, 32'd4});
            idx++;
         end
         tick();
      end
      check("mid_fresh_seen", 64'(idx), 64'd1);

      // Random traffic against a scoreboard.
      sent = 0; cyc = 0;
      while ((sent < 1000 || sb.size() != 0) && cyc < 20000) begin
         cmd_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
         cmd_a     = $urandom;
         cmd_b     = $urandom;
         cmd_s     = 3'($urandom_range(0, 7));
         res_ready = ($urandom_range(0, 1) != 0);
         taken  = cmd_valid && cmd_ready;
         popped = res_valid && res_ready;
         check("rnd_ready_full", 64'(cmd_ready && (count == 3'd4)), 64'd0);
         if (popped) begin
            if (sb.size() == 0) check("rnd_pop_empty", 64'd1, 64'd0);
            else check("rnd_res", {29'd0, res_op, res_data}, {29'd0, sb.pop_front()});
         end
         if (taken) begin
            sb.push_back({cmd_s, model(cmd_a, cmd_b, cmd_s)});
            sent++;
         end
         tick();
         cyc++;
      end
      cmd_valid = 1'b0;
      check("rnd_sent",      64'(sent),      64'd1000);
      check("rnd_sb_empty",  64'(sb.size()), 64'd0);
      check("rnd_res_valid", 64'(res_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
